// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the program-counter block.
//   OPC_*  : raw 3-bit opcode values carried on op_i
//   op_e   : enum view of the same opcodes, used by the next-PC decoder
// The codes 110 and 111 have no enum member; decoders treat them as NEXT.
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [2:0] OPC_NEXT   = 3'b000;
   localparam logic [2:0] OPC_JUMP   = 3'b001;
   localparam logic [2:0] OPC_BRANCH = 3'b010;
   localparam logic [2:0] OPC_CALL   = 3'b011;
   localparam logic [2:0] OPC_RET    = 3'b100;
   localparam logic [2:0] OPC_HOLD   = 3'b101;

   typedef enum logic [2:0] {
      OP_NEXT   = OPC_NEXT,
      OP_JUMP   = OPC_JUMP,
      OP_BRANCH = OPC_BRANCH,
      OP_CALL   = OPC_CALL,
      OP_RET    = OPC_RET,
      OP_HOLD   = OPC_HOLD
   } op_e;

endpackage

// File: rtl/pc_stack_if.sv
// ---------------------------------------------------------------------------
// pc_stack_if
// Bundles the control and status signals of pc_stack.
//   en_i, op_i, tgt_i, err_clr_i  : driven by the controller (master)
//   pc_o, sp_o, full_o, empty_o,
//   ovf_o, unf_o                  : driven by pc_stack (slave)
// Signal suffixes are named from the pc_stack point of view.
// ---------------------------------------------------------------------------
interface pc_stack_if #(
   parameter int AW    = 8,
   parameter int DEPTH = 4
);

   localparam int SPW = $clog2(DEPTH + 1);

   logic           en_i;
   logic [2:0]     op_i;
   logic [AW-1:0]  tgt_i;
   logic           err_clr_i;
   logic [AW-1:0]  pc_o;
   logic [SPW-1:0] sp_o;
   logic           full_o;
   logic           empty_o;
   logic           ovf_o;
   logic           unf_o;

   modport master (
      output en_i, op_i, tgt_i, err_clr_i,
      input  pc_o, sp_o, full_o, empty_o, ovf_o, unf_o
   );

   modport slave (
      input  en_i, op_i, tgt_i, err_clr_i,
      output pc_o, sp_o, full_o, empty_o, ovf_o, unf_o
   );

endinterface

// File: rtl/ret_stack.sv
// ---------------------------------------------------------------------------
// ret_stack
// LIFO of return addresses.
//   clk_i, rst_ni : clock, async active-low reset (resets occupancy only)
//   push_i, data_i: push data_i; ignored when full
//   pop_i         : discard top entry; ignored when empty
//   top_o         : current top entry (meaningless when empty)
//   sp_o          : occupancy, 0..DEPTH
//   full_o/empty_o: decode of sp_o
// ---------------------------------------------------------------------------
module ret_stack #(
   parameter int AW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [AW-1:0]                data_i,
   output logic [AW-1:0]                top_o,
   output logic [$clog2(DEPTH+1)-1:0]   sp_o,
   output logic                         full_o,
   output logic                         empty_o
);

   localparam int SPW   = $clog2(DEPTH + 1);
   // Slot index width; storage is rounded up to a power of two so every
   // index value is in range, the spare slots are simply never written.
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NSLOT = 1 << IW;

   logic [AW-1:0]  mem_q [NSLOT];
   logic [SPW-1:0] sp_q;
   logic [SPW-1:0] sp_d;
   logic [IW-1:0]  wrIdx;
   logic [IW-1:0]  topIdx;
   logic           doPush;
   logic           doPop;

   assign full_o  = (sp_q == SPW'(DEPTH));
   assign empty_o = (sp_q == '0);
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;

   // Whenever a push is allowed sp_q < DEPTH, so its low bits address the
   // next free slot; the top sits one below (modulo slot count is exact).
   assign wrIdx  = sp_q[IW-1:0];
   assign topIdx = sp_q[IW-1:0] - IW'(1);
   assign top_o  = mem_q[topIdx];
   assign sp_o   = sp_q;

   // Occupancy update: push has priority, though the PC logic never
   // requests both at once.
   always_comb begin
      sp_d = sp_q;
      if (doPush) begin
         sp_d = sp_q + SPW'(1);
      end else if (doPop) begin
         sp_d = sp_q - SPW'(1);
      end
   end

   // Occupancy register; a reset discards everything on the stack.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // Entry storage carries no reset; stale entries are unreachable once
   // sp_q has been cleared.
   always_ff @(posedge clk_i) begin
      if (doPush) begin
         mem_q[wrIdx] <= data_i;
      end
   end

endmodule

// File: rtl/pc_stack.sv
// ---------------------------------------------------------------------------
// pc_stack
// Program counter with a call/return stack and sticky error flags.
//   clk_i   : clock, all updates on the rising edge
//   rst_ni  : async active-low reset, pc -> RST_VEC, stack emptied, flags 0
//   bus     : pc_stack_if slave port
//             en_i advance strobe, op_i opcode, tgt_i target/offset,
//             err_clr_i flag clear; pc_o registered PC, sp_o occupancy,
//             full_o/empty_o occupancy decode, ovf_o/unf_o sticky errors
// ---------------------------------------------------------------------------
module pc_stack
   import cpu_pkg::*;
#(
   parameter int            AW      = 8,
   parameter int            DEPTH   = 4,
   parameter logic [AW-1:0] RST_VEC = '0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   pc_stack_if.slave   bus
);

   localparam int SPW = $clog2(DEPTH + 1);

   logic [AW-1:0]  pc_q;
   logic [AW-1:0]  pc_d;
   logic           ovf_q;
   logic           ovf_d;
   logic           unf_q;
   logic           unf_d;
   logic [AW-1:0]  pcInc;
   logic [AW-1:0]  stackTop;
   logic [SPW-1:0] stackSp;
   logic           stackFull;
   logic           stackEmpty;
   logic           pushReq;
   logic           popReq;
   op_e            opDec;

   assign opDec = op_e'(bus.op_i);
   assign pcInc = pc_q + AW'(1);

   ret_stack #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) uStack (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (pushReq),
      .pop_i   (popReq),
      .data_i  (pcInc),
      .top_o   (stackTop),
      .sp_o    (stackSp),
      .full_o  (stackFull),
      .empty_o (stackEmpty)
   );

   // Next-PC mux, stack requests and flag updates. The clear is applied
   // first so that an error raised on the same edge wins over the clear,
   // and the clear still works while en_i is low. Unused opcodes fall into
   // the default branch and behave as NEXT. BRANCH is a plain modular add:
   // a two's-complement offset needs no sign handling at equal widths.
   always_comb begin
      pc_d    = pc_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      pushReq = 1'b0;
      popReq  = 1'b0;

      if (bus.err_clr_i) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end

      if (bus.en_i) begin
         case (opDec)
            OP_NEXT:   pc_d = pcInc;
            OP_JUMP:   pc_d = bus.tgt_i;
            OP_BRANCH: pc_d = pc_q + bus.tgt_i;
            OP_HOLD:   pc_d = pc_q;
            OP_CALL: begin
               pc_d = bus.tgt_i;
               if (stackFull) begin
                  ovf_d = 1'b1;
               end else begin
                  pushReq = 1'b1;
               end
            end
            OP_RET: begin
               if (stackEmpty) begin
                  pc_d  = pcInc;
                  unf_d = 1'b1;
               end else begin
                  pc_d   = stackTop;
                  popReq = 1'b1;
               end
            end
            default:   pc_d = pcInc;
         endcase
      end
   end

   // PC and sticky flag registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q  <= RST_VEC;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.pc_o    = pc_q;
   assign bus.sp_o    = stackSp;
   assign bus.full_o  = stackFull;
   assign bus.empty_o = stackEmpty;
   assign bus.ovf_o   = ovf_q;
   assign bus.unf_o   = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// ---------------------------------------------------------------------------
// tb_pc_stack
// Directed, table-driven bench for pc_stack with AW=8, DEPTH=4, RST_VEC=0.
// ---------------------------------------------------------------------------
module tb_pc_stack;
   import cpu_pkg::*;

   typedef struct packed {
      logic       en;
      logic [2:0] op;
      logic [7:0] tgt;
      logic       clr;
      logic [7:0] pc;
      logic [2:0] sp;
      logic       full;
      logic       empty;
      logic       ovf;
      logic       unf;
   } vec_t;

   logic clock;
   logic rstN;
   int   checkCount;
   int   passCount;
   vec_t vecs[$];

   pc_stack_if #(.AW(8), .DEPTH(4)) ifc ();

   pc_stack #(
      .AW      (8),
      .DEPTH   (4),
      .RST_VEC (8'h00)
   ) dut (
      .clk_i  (clock),
      .rst_ni (rstN),
      .bus    (ifc)
   );

   // Free-running 10-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Drive one set of inputs, let one rising edge pass, then settle.
   task automatic applyStimulus(input logic en, input logic [2:0] op,
                                input logic [7:0] tgt, input logic clr);
      ifc.en_i      = en;
      ifc.op_i      = op;
      ifc.tgt_i     = tgt;
      ifc.err_clr_i = clr;
      @(posedge clock);
      #1;
   endtask

   task automatic checkField(input string tag, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s.%s: got %0h, expected %0h", tag, field, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] pc,
                              input logic [2:0] sp, input logic full,
                              input logic empty, input logic ovf,
                              input logic unf);
      checkField(tag, "pc",    32'(ifc.pc_o),    32'(pc));
      checkField(tag, "sp",    32'(ifc.sp_o),    32'(sp));
      checkField(tag, "full",  32'(ifc.full_o),  32'(full));
      checkField(tag, "empty", 32'(ifc.empty_o), 32'(empty));
      checkField(tag, "ovf",   32'(ifc.ovf_o),   32'(ovf));
      checkField(tag, "unf",   32'(ifc.unf_o),   32'(unf));
   endtask

   task automatic addVec(input logic en, input logic [2:0] op,
                         input logic [7:0] tgt, input logic clr,
                         input logic [7:0] pc, input logic [2:0] sp,
                         input logic full, input logic empty,
                         input logic ovf, input logic unf);
      vec_t v;
      v = '{en, op, tgt, clr, pc, sp, full, empty, ovf, unf};
      vecs.push_back(v);
   endtask

   initial begin
      logic [7:0] expPc;
      checkCount = 0;
      passCount  = 0;

      // Expected results, starting from pc=0x00 with an empty stack.
      //     en    op          tgt    clr   pc     sp    full  empty ovf   unf
      addVec(1'b1, OPC_JUMP,   8'h40, 1'b0, 8'h40, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      addVec(1'b1, OPC_BRANCH, 8'hFE, 1'b0, 8'h3E, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      addVec(1'b1, OPC_BRANCH, 8'h05, 1'b0, 8'h43, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      addVec(1'b1, OPC_JUMP,   8'h10, 1'b0, 8'h10, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      addVec(1'b1, OPC_CALL,   8'h80, 1'b0, 8'h80, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      addVec(1'b1, OPC_CALL,   8'h90, 1'b0, 8'h90, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      addVec(1'b1, OPC_RET,    8'h00, 1'b0, 8'h81, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      addVec(1'b1, OPC_RET,    8'h00, 1'b0, 8'h11, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      addVec(1'b1, OPC_HOLD,   8'h55, 1'b0, 8'h11, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      addVec(1'b1, 3'b110,     8'h55, 1'b0, 8'h12, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      addVec(1'b1, 3'b111,     8'h55, 1'b0, 8'h13, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      addVec(1'b0, OPC_NEXT,   8'h00, 1'b0, 8'h13, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      addVec(1'b1, OPC_JUMP,   8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      // Five nested calls: the fifth overflows.
      addVec(1'b1, OPC_CALL,   8'h20, 1'b0, 8'h20, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      addVec(1'b1, OPC_CALL,   8'h30, 1'b0, 8'h30, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      addVec(1'b1, OPC_CALL,   8'h40, 1'b0, 8'h40, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      addVec(1'b1, OPC_CALL,   8'h50, 1'b0, 8'h50, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      addVec(1'b1, OPC_CALL,   8'h60, 1'b0, 8'h60, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      // Four pops, then a return from an empty stack.
      addVec(1'b1, OPC_RET,    8'h00, 1'b0, 8'h41, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      addVec(1'b1, OPC_RET,    8'h00, 1'b0, 8'h31, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      addVec(1'b1, OPC_RET,    8'h00, 1'b0, 8'h21, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      addVec(1'b1, OPC_RET,    8'h00, 1'b0, 8'h01, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      addVec(1'b1, OPC_RET,    8'h00, 1'b0, 8'h02, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      // Clear while disabled, then clear and a new underflow on one edge.
      addVec(1'b0, OPC_RET,    8'h00, 1'b1, 8'h02, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      addVec(1'b1, OPC_RET,    8'h00, 1'b1, 8'h03, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      addVec(1'b0, OPC_NEXT,   8'h00, 1'b1, 8'h03, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      // Build sp=2, then disabled CALLs must change nothing.
      addVec(1'b1, OPC_JUMP,   8'h10, 1'b0, 8'h10, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      addVec(1'b1, OPC_CALL,   8'h80, 1'b0, 8'h80, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      addVec(1'b1, OPC_CALL,   8'h90, 1'b0, 8'h90, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      addVec(1'b0, OPC_CALL,   8'hAA, 1'b0, 8'h90, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      addVec(1'b0, OPC_CALL,   8'hAA, 1'b0, 8'h90, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      addVec(1'b0, OPC_CALL,   8'hAA, 1'b0, 8'h90, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset is held across a rising edge with inputs idle.
      ifc.en_i      = 1'b0;
      ifc.op_i      = OPC_NEXT;
      ifc.tgt_i     = 8'h00;
      ifc.err_clr_i = 1'b0;
      rstN          = 1'b0;
      #12;
      checkOutput("reset", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      rstN = 1'b1;

      // 256 NEXTs walk the full PC range and wrap to zero.
      for (int i = 1; i <= 256; i++) begin
         applyStimulus(1'b1, OPC_NEXT, 8'h00, 1'b0);
         expPc = 8'(i);
         checkOutput($sformatf("next%0d", i), expPc, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      end

      for (int k = 0; k < vecs.size(); k++) begin
         applyStimulus(vecs[k].en, vecs[k].op, vecs[k].tgt, vecs[k].clr);
         checkOutput($sformatf("vec%0d", k), vecs[k].pc, vecs[k].sp,
                     vecs[k].full, vecs[k].empty, vecs[k].ovf, vecs[k].unf);
      end

      // Asynchronous reset pulse between edges with sp=2 and en_i low.
      #1 rstN = 1'b0;
      #1 checkOutput("asyncRst", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      rstN = 1'b1;

      // Normal execution resumes from RST_VEC with the old entries gone.
      applyStimulus(1'b1, OPC_NEXT, 8'h00, 1'b0);
      checkOutput("postRstNext", 8'h01, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, OPC_RET, 8'h00, 1'b0);
      checkOutput("postRstRet", 8'h02, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
